disteu_core: RTL and testbench

DISTEU_CORE -- requirements
Module: disteu

---
 rtl/disteu_core.sv | 204 ++++++++++++++++++++
 tb/tb_disteu_core.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/disteu_core.sv
// Vector-quantisation distortion engine: sum over frames of the min squared distance to a codebook.
// Build option: define DISTEU_SAT_EN to saturate the 30-bit total instead of wrapping.
module disteu_core #(
  parameter int unsigned NUM_CW     = 8,
  parameter int unsigned CW_STRIDE  = 40,
  parameter int unsigned MAX_FRAMES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [8:0]  rd_data_d,
  output logic [12:0] rd_addr_d,
  input  logic [8:0]  rd_data_r,
  output logic [10:0] rd_addr_r,
  input  logic        cfg_valid,
  input  logic [8:0]  cfg_data,
  input  logic        cfg_last,
  input  logic [5:0]  cfg_mode_data,
  output logic        o_ready,
  output logic        o_valid,
  output logic [29:0] o_data
);

  localparam int unsigned IdxW = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;
  localparam int unsigned CntW = $clog2(MAX_FRAMES + 1);
  localparam int unsigned CwW  = (NUM_CW > 1) ? $clog2(NUM_CW) : 1;

  typedef enum logic [1:0] {StIdle, StCompute, StDone} state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [5:0]        d_q;
  logic              issuing_q;
  logic [IdxW-1:0]   fi_q;
  logic [CwW-1:0]    c_q;
  logic [5:0]        k_q;
  logic              s1_valid_q, s1_last_k_q, s1_last_c_q, s1_last_f_q;
  logic              s2_valid_q, s2_last_k_q, s2_last_c_q, s2_last_f_q;
  logic [25:0]       dist_q;
  logic [25:0]       min_q;
  logic [29:0]       total_q;
  logic              o_ready_q, o_valid_q;
  logic [29:0]       o_data_q;
  logic [12:0]       rd_addr_d_q;
  logic [10:0]       rd_addr_r_q;

  logic [8:0]        frame_buf [MAX_FRAMES];
  logic [8:0]        frame_sel;
  logic              buf_we;
  logic              k_last, c_last, f_last;
  logic [9:0]        diff;
  logic [8:0]        mag;
  logic [18:0]       sq;
  logic [25:0]       cand;
  logic [25:0]       frame_min;
  logic [29:0]       total_nxt;
`ifdef DISTEU_SAT_EN
  logic [30:0]       total_sum;
`endif

  assign buf_we    = (state_q == StIdle) && cfg_valid && (cnt_q < CntW'(MAX_FRAMES));
  assign frame_sel = frame_buf[fi_q];
  assign k_last    = (k_q == d_q - 6'd1);
  assign c_last    = (c_q == CwW'(NUM_CW - 1));
  assign f_last    = (CntW'(fi_q) == cnt_q - CntW'(1));

  always_ff @(posedge clk) begin
    if (buf_we) begin
      frame_buf[IdxW'(cnt_q)] <= cfg_data;
    end
  end

  // Stage-2 datapath: memory data for the address issued two edges earlier.
  always_comb begin
    diff      = {rd_data_d[8], rd_data_d} - {rd_data_r[8], rd_data_r};
    mag       = 9'(diff[9] ? -diff : diff);
    sq        = 19'(mag) * 19'(mag);
    cand      = dist_q + 26'(sq);
    frame_min = (cand < min_q) ? cand : min_q;
`ifdef DISTEU_SAT_EN
    total_sum = {1'b0, total_q} + 31'(frame_min);
    total_nxt = total_sum[30] ? '1 : total_sum[29:0];
`else
    total_nxt = total_q + 30'(frame_min);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      d_q         <= '0;
      issuing_q   <= 1'b0;
      fi_q        <= '0;
      c_q         <= '0;
      k_q         <= '0;
      s1_valid_q  <= 1'b0;
      s1_last_k_q <= 1'b0;
      s1_last_c_q <= 1'b0;
      s1_last_f_q <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_last_k_q <= 1'b0;
      s2_last_c_q <= 1'b0;
      s2_last_f_q <= 1'b0;
      dist_q      <= '0;
      min_q       <= '1;
      total_q     <= '0;
      o_ready_q   <= 1'b1;
      o_valid_q   <= 1'b0;
      o_data_q    <= '0;
      rd_addr_d_q <= '0;
      rd_addr_r_q <= '0;
    end else begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= s1_valid_q;
      s2_last_k_q <= s1_last_k_q;
      s2_last_c_q <= s1_last_c_q;
      s2_last_f_q <= s1_last_f_q;
      unique case (state_q)
        StIdle: begin
          if (cfg_valid) begin
            if (buf_we) begin
              cnt_q <= cnt_q + CntW'(1);
            end
            // Last beat ends configuration even when the buffer is full.
            if (cfg_last) begin
              state_q   <= StCompute;
              o_ready_q <= 1'b0;
              d_q       <= cfg_mode_data;
              issuing_q <= (cfg_mode_data != 6'd0);
              fi_q      <= '0;
              c_q       <= '0;
              k_q       <= '0;
              dist_q    <= '0;
              min_q     <= '1;
              total_q   <= '0;
            end
          end
        end
        StCompute: begin
          if (d_q == 6'd0) begin
            state_q   <= StDone;
            o_valid_q <= 1'b1;
            o_data_q  <= '0;
          end
          s1_valid_q <= issuing_q;
          if (issuing_q) begin
            rd_addr_d_q <= 13'(16'(frame_sel) * 16'(d_q) + 16'(k_q));
            rd_addr_r_q <= 11'(32'(c_q) * CW_STRIDE + 32'(k_q));
            s1_last_k_q <= k_last;
            s1_last_c_q <= c_last;
            s1_last_f_q <= f_last;
            if (k_last) begin
              k_q <= '0;
              if (c_last) begin
                c_q <= '0;
                if (f_last) begin
                  issuing_q <= 1'b0;
                end else begin
                  fi_q <= fi_q + IdxW'(1);
                end
              end else begin
                c_q <= c_q + CwW'(1);
              end
            end else begin
              k_q <= k_q + 6'd1;
            end
          end
          if (s2_valid_q) begin
            if (s2_last_k_q) begin
              dist_q <= '0;
              if (s2_last_c_q) begin
                min_q   <= '1;
                total_q <= total_nxt;
                if (s2_last_f_q) begin
                  state_q   <= StDone;
                  o_valid_q <= 1'b1;
                  o_data_q  <= total_nxt;
                end
              end else begin
                min_q <= frame_min;
              end
            end else begin
              dist_q <= cand;
            end
          end
        end
        StDone: begin
          state_q   <= StIdle;
          o_valid_q <= 1'b0;
          o_ready_q <= 1'b1;
          cnt_q     <= '0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_ready   = o_ready_q;
  assign o_valid   = o_valid_q;
  assign o_data    = o_data_q;
  assign rd_addr_d = rd_addr_d_q;
  assign rd_addr_r = rd_addr_r_q;

endmodule

// File: tb/tb_disteu_core.sv
// Scoreboard bench for disteu_core: randomized jobs against a plain-arithmetic distortion model.
module tb_disteu_core;
  localparam int NCW  = 8;
  localparam int STR  = 40;
  localparam int MAXF = 256;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [8:0]  rd_data_d, rd_data_r;
  logic [12:0] rd_addr_d;
  logic [10:0] rd_addr_r;
  logic        cfg_valid, cfg_last;
  logic [8:0]  cfg_data;
  logic [5:0]  cfg_mode_data;
  logic        o_ready, o_valid;
  logic [29:0] o_data;

  logic [8:0]  mem_d [8192];
  logic [8:0]  mem_r [2048];

  int          compared   = 0;
  int          mismatched = 0;
  int          n_results  = 0;
  logic [29:0] exp_q[$];
  logic [29:0] held_exp = '0;
  int unsigned frm_q[$];

  disteu_core #(.NUM_CW(NCW), .CW_STRIDE(STR), .MAX_FRAMES(MAXF)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rd_data_d    (rd_data_d),
    .rd_addr_d    (rd_addr_d),
    .rd_data_r    (rd_data_r),
    .rd_addr_r    (rd_addr_r),
    .cfg_valid    (cfg_valid),
    .cfg_data     (cfg_data),
    .cfg_last     (cfg_last),
    .cfg_mode_data(cfg_mode_data),
    .o_ready      (o_ready),
    .o_valid      (o_valid),
    .o_data       (o_data)
  );

  always #5 clk = ~clk;

  // Synchronous-read memories.
  always @(posedge clk) begin
    rd_data_d <= mem_d[rd_addr_d];
    rd_data_r <= mem_r[rd_addr_r];
  end

  task automatic check(input string name, input longint act, input longint exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint model(input int d);
    longint tot = 0;
    int n = (frm_q.size() > MAXF) ? MAXF : frm_q.size();
    for (int f = 0; f < n; f++) begin
      longint best = -1;
      for (int c = 0; c < NCW; c++) begin
        longint s = 0;
        for (int k = 0; k < d; k++) begin
          int a  = (int'(frm_q[f]) * d + k) % 8192;
          int b  = (c * STR + k) % 2048;
          int dv = $signed(mem_d[a]);
          int rv = $signed(mem_r[b]);
          s += longint'((dv - rv) * (dv - rv));
        end
        if (best < 0 || s < best) best = s;
      end
      tot += best;
`ifdef DISTEU_SAT_EN
      if (tot > 64'd1073741823) tot = 64'd1073741823;
`else
      tot = tot % (64'd1 << 30);
`endif
    end
    return tot;
  endfunction

  task automatic fill_rand();
    for (int i = 0; i < 8192; i++) mem_d[i] = 9'($urandom);
    for (int i = 0; i < 2048; i++) mem_r[i] = 9'($urandom);
  endtask

  task automatic rand_frames(input int n);
    frm_q.delete();
    for (int i = 0; i < n; i++) frm_q.push_back($urandom_range(0, 511));
  endtask

  task automatic run_job(input int d, input bit push, input logic [29:0] expv, input bit wait_res);
    int target, n, budget, i;
    i = 0;
    while (!o_ready && i < 200) begin
      @(negedge clk);
      i++;
    end
    check("ready_before_job", o_ready, 1);
    if (push) exp_q.push_back(expv);
    target = n_results + 1;
    for (int j = 0; j < frm_q.size(); j++) begin
      @(negedge clk);
      cfg_valid     = 1'b1;
      cfg_data      = 9'(frm_q[j]);
      cfg_last      = (j == frm_q.size() - 1);
      cfg_mode_data = 6'(d);
    end
    @(negedge clk);
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
    if (wait_res) begin
      n      = (frm_q.size() > MAXF) ? MAXF : frm_q.size();
      budget = n * NCW * (d + 4) + 16;
      i      = 0;
      while (n_results < target && i < budget) begin
        @(negedge clk);
        i++;
      end
      check("result_within_latency", longint'(n_results >= target), 1);
      @(negedge clk);
    end
  endtask

  // Monitor: pops the scoreboard whenever a result strobe is seen.
  initial begin
    bit          prev_v;
    logic [29:0] e;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_v = 1'b0;
      end else begin
        if (prev_v) begin
          check("ready_after_valid", o_ready, 1);
          check("valid_one_cycle", o_valid, 0);
        end
        if (o_valid) begin
          if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_result: got o_data=%0d, expected no result", o_data);
          end else begin
            e = exp_q.pop_front();
            check("result", o_data, e);
            held_exp = e;
          end
          n_results++;
        end
        prev_v = o_valid;
      end
    end
  end

  initial begin
    int d;
    rst_n = 1'b0;
    cfg_valid = 1'b0;
    cfg_last = 1'b0;
    cfg_data = '0;
    cfg_mode_data = '0;
    fill_rand();
    repeat (3) @(negedge clk);
    check("rst_o_ready", o_ready, 1);
    check("rst_o_valid", o_valid, 0);
    check("rst_o_data", o_data, 0);
    check("rst_rd_addr_d", rd_addr_d, 0);
    check("rst_rd_addr_r", rd_addr_r, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Address generation: frame 5, D=39.
    frm_q.delete();
    frm_q.push_back(5);
    fork
      run_job(39, 1'b1, 30'(model(39)), 1'b1);
      begin
        for (int i = 0; i < 100 && rd_addr_d == 0; i++) @(negedge clk);
        check("first_rd_addr_d", rd_addr_d, 195);
        check("first_rd_addr_r", rd_addr_r, 0);
        for (int i = 0; i < 400 && rd_addr_r != 120; i++) @(negedge clk);
        check("cw3_rd_addr_r", rd_addr_r, 120);
        check("cw3_rd_addr_d", rd_addr_d, 195);
      end
    join

    // Minimum selection across codewords.
    for (int i = 0; i < 8192; i++) mem_d[i] = '0;
    for (int i = 0; i < 2048; i++) mem_r[i] = '0;
    mem_r[0] = 9'd3;   mem_r[40] = 9'd1;  mem_r[80] = 9'd4;  mem_r[120] = 9'd1;
    mem_r[160] = 9'd5; mem_r[200] = 9'd9; mem_r[240] = 9'd2; mem_r[280] = 9'd6;
    frm_q.delete();
    frm_q.push_back(0);
    frm_q.push_back(1);
    run_job(1, 1'b1, 30'd2, 1'b1);

    // Signed extremes.
    mem_d[7] = 9'h100;
    for (int c = 0; c < NCW; c++) mem_r[c * STR] = 9'd255;
    frm_q.delete();
    frm_q.push_back(7);
    run_job(1, 1'b1, 30'd261121, 1'b1);

    // D = 0 yields zero.
    frm_q.delete();
    frm_q.push_back(3);
    frm_q.push_back(9);
    run_job(0, 1'b1, 30'd0, 1'b1);

    // Total overflow.
    for (int i = 0; i < 8192; i++) mem_d[i] = 9'h100;
    for (int i = 0; i < 2048; i++) mem_r[i] = 9'd255;
    rand_frames(200);
`ifdef DISTEU_SAT_EN
    run_job(39, 1'b1, 30'd1073741823, 1'b1);
`else
    run_job(39, 1'b1, 30'd963001976, 1'b1);
`endif

    // Beats during COMPUTE are ignored; output holds the previous result meanwhile.
    fill_rand();
    rand_frames(3);
    fork
      run_job(20, 1'b1, 30'(model(20)), 1'b1);
      begin
        for (int i = 0; i < 50 && o_ready; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        repeat (4) begin
          cfg_valid = 1'b1;
          cfg_last  = 1'b1;
          cfg_data  = 9'($urandom);
          @(negedge clk);
        end
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
        check("o_data_held", o_data, held_exp);
        check("busy_o_ready", o_ready, 0);
      end
    join

    // Reset mid-compute: no result may emerge from the aborted job.
    fill_rand();
    rand_frames(4);
    run_job(30, 1'b0, 30'd0, 1'b0);
    repeat (40) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_o_ready", o_ready, 1);
    check("abort_o_valid", o_valid, 0);
    check("abort_o_data", o_data, 0);
    check("abort_rd_addr_d", rd_addr_d, 0);
    check("abort_rd_addr_r", rd_addr_r, 0);
    held_exp = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rand_frames(3);
    run_job(25, 1'b1, 30'(model(25)), 1'b1);

    // Randomized jobs.
    for (int j = 0; j < 6; j++) begin
      fill_rand();
      d = $urandom_range(1, 40);
      rand_frames($urandom_range(1, 4));
      run_job(d, 1'b1, 30'(model(d)), 1'b1);
    end

    // Frame buffer overflow: beats past MAX_FRAMES are dropped.
    fill_rand();
    rand_frames(MAXF + 4);
    run_job(1, 1'b1, 30'(model(1)), 1'b1);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
